data_mem_hs: RTL and testbench
==============================

Name: data_mem_hs

Overview:
- Parametrised single-port data memory for the nRisc datapath.
- Replaces the fixed 8x256 memory: width, depth and access latency are configurable.
- Adds a req/ack handshake, an optional zero-fill sequence after reset, and a held read-data register.
- Sits between the control unit/datapath and storage; the control unit stalls the pipeline on busy and until ack.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 8, address width; DEPTH = 2**ADDR_W words
WAIT_STATES, 0, extra cycles inserted between request accept and access (0..15)
CLEAR_ON_RESET, 1, 1 = zero-fill all words after reset; 0 = skip the fill (contents undefined)

Ports:
clock  in  1  single clock; all state changes on posedge
reset_n  in  1  asynchronous active-low reset
req  in  1  request; held high by the master until ack is seen
we  in  1  1 = write, 0 = read; sampled with req on accept
addr  in  ADDR_W  word address; sampled on accept
wdata  in  DATA_W  write data; sampled on accept
rdata  out  DATA_W  read data; holds its value until the next read completes
ack  out  1  one-cycle completion pulse
busy  out  1  high while in CLEAR or while a transaction is in flight

Behaviour:
- Reset (reset_n low, asynchronous): the following take effect immediately.
  - state = CLEAR if CLEAR_ON_RESET, else IDLE.
  - clr_addr = 0, wait counter = 0.
  - rdata = 0, ack = 0, busy = 1 if CLEAR_ON_RESET, else 0.
- Reset mid-transaction or mid-fill: the transaction is aborted with no ack, and the fill restarts from address 0.
- The memory array itself is not reset.
- Registered outputs: busy and ack are decoded from the registered state.
  - busy = (state != IDLE).
  - ack = (state == ACK).
- FSM states: CLEAR, IDLE, WAIT, ACK.
- CLEAR:
  - Each posedge writes 0 to mem[clr_addr], then clr_addr increments.
  - On the edge that writes DEPTH-1, the FSM moves to IDLE.
  - The fill takes exactly DEPTH cycles; req is ignored throughout.
- IDLE:
  - At a posedge with req = 1, capture we, addr and wdata; load counter = WAIT_STATES; go to WAIT.
  - With req = 0, stay in IDLE.
- WAIT:
  - While counter != 0, decrement it each posedge.
  - At the posedge with counter == 0, perform the access and go to ACK.
  - Write access: mem[addr_q] <= wdata_q.
  - Read access: rdata <= mem[addr_q].
  - Inputs are not re-sampled during WAIT, so changes to addr, wdata or we after accept have no effect.
- ACK:
  - ack = 1 for exactly one cycle, then unconditionally return to IDLE.
  - The master drops req on the edge following ack.
  - req still high when the FSM is back in IDLE starts a new transaction.
- Latency: accept edge E0; ack is visible in the cycle after edge E0+1+WAIT_STATES.
  - Minimum transaction period is WAIT_STATES+3 cycles.
- rdata: changes only on read completion; writes and fill leave it unchanged.
- Read-after-write to the same address returns the new data, because the write completes before the next accept.
- Address wrap: none needed; every ADDR_W value is a valid word.
- Widths: no truncation; addr and data are used at full parameter width.

Test Plan (DATA_W = 8, ADDR_W = 8, WAIT_STATES = 2, CLEAR_ON_RESET = 1 unless noted):
- Release reset_n -> busy stays 1 for exactly 256 cycles, then falls to 0; a read of addr 0x7F then returns rdata = 0x00.
- Write 0xA5 to 0x10, then read 0x10 -> each ack pulses one cycle, 4 cycles after the accept edge; rdata = 0xA5 and holds through a following write of 0x3C to 0x11.
- req asserted during CLEAR at cycle 100 -> no accept and no ack until busy falls; accept occurs on the first IDLE edge.
- Change addr and wdata during WAIT after accepting a write of 0x55 to 0x20 -> mem[0x20] = 0x55 on read-back; the new addr location is unchanged.
- Pull reset_n low during WAIT of a write to 0x30 -> ack never pulses, busy re-enters the fill immediately, and mem[0x30] reads 0x00 after the fill.
- WAIT_STATES = 0, CLEAR_ON_RESET = 0 -> busy = 0 immediately after reset; ack appears 2 cycles after accept; back-to-back reads complete every 3 cycles.

Source files
------------

// File: rtl/data_mem_hs_if.sv
// Request/acknowledge bus between the nRisc control unit and data_mem_hs.
// The master holds req until it sees ack; the slave reports busy and holds rdata.
interface data_mem_hs_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              busy;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack, busy
  );
endinterface

// File: rtl/data_mem_hs.sv
// Parametrised single-port data memory with req/ack handshake, programmable wait
// states, optional zero-fill after reset and a held read-data register.
module data_mem_hs #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned WAIT_STATES    = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic          clock,
  input  logic          reset_n,
  data_mem_hs_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = 4;

  localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'(WAIT_STATES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic              FILL_EN   = 1'(CLEAR_ON_RESET != 0);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  localparam state_e RESET_STATE = FILL_EN ? ST_CLEAR : ST_IDLE;

  state_e            state_q,    state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic              we_q,       we_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [DATA_W-1:0] wdata_q,    wdata_d;
  logic [DATA_W-1:0] rdata_q,    rdata_d;
  logic              ack_q,      ack_d;
  logic              busy_q,     busy_d;

  logic              mem_wr_c;
  logic [ADDR_W-1:0] mem_waddr_c;
  logic [DATA_W-1:0] mem_wdata_c;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Next-state, capture and memory-port decode
  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    mem_wr_c    = 1'b0;
    mem_waddr_c = addr_q;
    mem_wdata_c = wdata_q;

    case (state_q)
      ST_CLEAR: begin
        mem_wr_c    = 1'b1;
        mem_waddr_c = clr_addr_q;
        mem_wdata_c = '0;
        clr_addr_d  = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == LAST_ADDR) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          cnt_d   = WAIT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          if (we_q) begin
            mem_wr_c = 1'b1;
          end else begin
            rdata_d = mem_q[addr_q];
          end
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase

    // Flags are registered from the next state so they mirror state_q exactly
    ack_d  = (state_d == ST_ACK);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RESET_STATE;
      clr_addr_q <= '0;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
      busy_q     <= FILL_EN;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
    end
  end

  // Storage array carries no reset; contents come from the fill or from writes
  always_ff @(posedge clock) begin
    if (mem_wr_c) begin
      mem_q[mem_waddr_c] <= mem_wdata_c;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_data_mem_hs.sv
// Bench for data_mem_hs: a 2-wait-state/zero-fill instance and a 0-wait/no-fill
// instance, both compared against array models of memory contents and handshake timing.
module tb_data_mem_hs;

  logic clk = 1'b0;
  logic rst0_n;
  logic rst1_n;
  always #5 clk = ~clk;

  data_mem_hs_if #(.DATA_W(8), .ADDR_W(8)) bus0 ();
  data_mem_hs_if #(.DATA_W(8), .ADDR_W(8)) bus1 ();

  data_mem_hs #(.DATA_W(8), .ADDR_W(8), .WAIT_STATES(2), .CLEAR_ON_RESET(1)) dut0 (
    .clock(clk), .reset_n(rst0_n), .bus(bus0.slave)
  );
  data_mem_hs #(.DATA_W(8), .ADDR_W(8), .WAIT_STATES(0), .CLEAR_ON_RESET(0)) dut1 (
    .clock(clk), .reset_n(rst1_n), .bus(bus1.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [7:0] m0 [256];
  logic [7:0] m1 [256];
  logic [7:0] exp_rd0;
  logic [7:0] exp_rd1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_model0();
    for (int i = 0; i < 256; i++) m0[i] = 8'h00;
  endtask

  // Issue one transaction from IDLE; lat = edges between accept and ack visible
  task automatic txn(input int sel, input bit we, input logic [7:0] a, input logic [7:0] d,
                     input bit hold, output logic [7:0] rd, output int lat,
                     output bit one_cycle, output bit to);
    int n;
    bit seen;
    n = 0;
    to = 1'b0;
    if (sel == 0) begin
      bus0.req = 1'b1; bus0.we = we; bus0.addr = a; bus0.wdata = d;
    end else begin
      bus1.req = 1'b1; bus1.we = we; bus1.addr = a; bus1.wdata = d;
    end
    seen = 1'b0;
    while (!seen && n < 64) begin
      tick();
      n++;
      seen = (sel == 0) ? bus0.ack : bus1.ack;
    end
    to  = !seen;
    lat = n - 1;
    rd  = (sel == 0) ? bus0.rdata : bus1.rdata;
    if (!hold) begin
      if (sel == 0) bus0.req = 1'b0; else bus1.req = 1'b0;
    end
    tick();
    one_cycle = !((sel == 0) ? bus0.ack : bus1.ack);
  endtask

  task automatic test_reset();
    int n;
    logic [7:0] rd;
    int lat;
    bit oc, to;
    rst0_n = 1'b0; rst1_n = 1'b0;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0;
    bus1.req = 1'b0; bus1.we = 1'b0; bus1.addr = '0; bus1.wdata = '0;
    repeat (2) tick();
    n_cmp++;
    if ({bus0.busy, bus0.ack, bus0.rdata} !== {1'b1, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset0_outputs: busy/ack/rdata got %b/%b/%h expected 1/0/00",
               bus0.busy, bus0.ack, bus0.rdata);
    end
    n_cmp++;
    if ({bus1.busy, bus1.ack, bus1.rdata} !== {1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset1_outputs: busy/ack/rdata got %b/%b/%h expected 0/0/00",
               bus1.busy, bus1.ack, bus1.rdata);
    end
    @(negedge clk);
    rst0_n = 1'b1; rst1_n = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        n_cmp++;
        if (bus1.busy !== 1'b0) begin
          n_fail++;
          $display("FAIL nofill_busy: got %b expected 0", bus1.busy);
        end
      end
    end while (bus0.busy && n < 400);
    n_cmp++;
    if (n !== 256) begin
      n_fail++;
      $display("FAIL fill_length: busy high for %0d cycles expected 256", n);
    end
    zero_model0();
    exp_rd0 = 8'h00;
    exp_rd1 = 8'h00;
    txn(0, 1'b0, 8'h7F, 8'h00, 1'b0, rd, lat, oc, to);
    n_cmp++;
    if (to || rd !== 8'h00) begin
      n_fail++;
      $display("FAIL read_after_fill: rdata %h timeout %b expected 00 timeout 0", rd, to);
    end
  endtask

  task automatic test_write_read();
    logic [7:0] rd;
    int lat;
    bit oc, to;
    txn(0, 1'b1, 8'h10, 8'hA5, 1'b0, rd, lat, oc, to);
    m0[8'h10] = 8'hA5;
    n_cmp++;
    if (to || lat !== 3 || !oc) begin
      n_fail++;
      $display("FAIL write_latency: lat %0d one_cycle %b timeout %b expected 3 1 0", lat, oc, to);
    end
    txn(0, 1'b0, 8'h10, 8'h00, 1'b0, rd, lat, oc, to);
    exp_rd0 = m0[8'h10];
    n_cmp++;
    if (to || lat !== 3 || !oc || rd !== 8'hA5) begin
      n_fail++;
      $display("FAIL read_back: rdata %h lat %0d one_cycle %b expected A5 3 1", rd, lat, oc);
    end
    txn(0, 1'b1, 8'h11, 8'h3C, 1'b0, rd, lat, oc, to);
    m0[8'h11] = 8'h3C;
    n_cmp++;
    if (bus0.rdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL rdata_hold: got %h expected A5", bus0.rdata);
    end
  endtask

  task automatic test_random();
    logic [7:0] rd, a, d;
    int lat;
    bit oc, to, we;
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 15)) + 8'h80;
      d  = 8'($urandom);
      txn(0, we, a, d, 1'b0, rd, lat, oc, to);
      if (we) m0[a] = d;
      else    exp_rd0 = m0[a];
      n_cmp++;
      if (to || lat !== 3 || !oc || rd !== exp_rd0) begin
        n_fail++;
        $display("FAIL random_txn%0d: we %b addr %h rdata %h lat %0d oc %b expected rdata %h lat 3",
                 i, we, a, rd, lat, oc, exp_rd0);
      end
    end
  endtask

  task automatic test_req_during_clear();
    int n, first_idle;
    bit seen;
    logic [7:0] d, rd;
    int lat;
    bit oc, to;
    @(negedge clk); rst0_n = 1'b0;
    @(negedge clk); rst0_n = 1'b1;
    zero_model0();
    exp_rd0 = 8'h00;
    n = 0;
    repeat (100) begin tick(); n++; end
    d = 8'($urandom);
    bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = 8'h40; bus0.wdata = d;
    first_idle = -1;
    seen = 1'b0;
    while (!seen && n < 400) begin
      tick();
      n++;
      if (!bus0.busy && first_idle < 0) first_idle = n;
      seen = bus0.ack;
    end
    bus0.req = 1'b0;
    tick();
    m0[8'h40] = d;
    n_cmp++;
    if (first_idle !== 256 || n !== 260) begin
      n_fail++;
      $display("FAIL req_in_clear: idle at %0d ack at %0d expected 256 and 260", first_idle, n);
    end
    txn(0, 1'b0, 8'h40, 8'h00, 1'b0, rd, lat, oc, to);
    exp_rd0 = d;
    n_cmp++;
    if (to || rd !== d) begin
      n_fail++;
      $display("FAIL clear_write_readback: got %h expected %h", rd, d);
    end
  endtask

  task automatic test_wait_change();
    logic [7:0] v, rd;
    int lat, n;
    bit oc, to, seen;
    v = 8'($urandom);
    txn(0, 1'b1, 8'h21, v, 1'b0, rd, lat, oc, to);
    m0[8'h21] = v;
    bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = 8'h20; bus0.wdata = 8'h55;
    tick();
    n_cmp++;
    if (bus0.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_accept: busy %b expected 1", bus0.busy);
    end
    bus0.we = 1'b0; bus0.addr = 8'h21; bus0.wdata = ~v;
    n = 0; seen = 1'b0;
    while (!seen && n < 64) begin tick(); n++; seen = bus0.ack; end
    bus0.req = 1'b0;
    tick();
    m0[8'h20] = 8'h55;
    txn(0, 1'b0, 8'h20, 8'h00, 1'b0, rd, lat, oc, to);
    n_cmp++;
    if (!seen || rd !== 8'h55) begin
      n_fail++;
      $display("FAIL wait_change_target: got %h ack_seen %b expected 55", rd, seen);
    end
    txn(0, 1'b0, 8'h21, 8'h00, 1'b0, rd, lat, oc, to);
    exp_rd0 = v;
    n_cmp++;
    if (rd !== v) begin
      n_fail++;
      $display("FAIL wait_change_other: got %h expected %h", rd, v);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit saw_ack;
    logic [7:0] rd;
    int lat;
    bit oc, to;
    bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = 8'h30; bus0.wdata = 8'h99;
    tick();
    tick();
    rst0_n = 1'b0;
    bus0.req = 1'b0;
    #1;
    n_cmp++;
    if (bus0.busy !== 1'b1 || bus0.ack !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_flags: busy/ack %b/%b expected 1/0", bus0.busy, bus0.ack);
    end
    saw_ack = 1'b0;
    repeat (3) begin tick(); saw_ack |= bus0.ack; end
    @(negedge clk);
    rst0_n = 1'b1;
    zero_model0();
    exp_rd0 = 8'h00;
    n = 0;
    do begin tick(); n++; saw_ack |= bus0.ack; end while (bus0.busy && n < 400);
    n_cmp++;
    if (saw_ack || n !== 256) begin
      n_fail++;
      $display("FAIL mid_reset_abort: ack_seen %b refill %0d expected 0 and 256", saw_ack, n);
    end
    txn(0, 1'b0, 8'h30, 8'h00, 1'b0, rd, lat, oc, to);
    n_cmp++;
    if (to || rd !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset_mem: got %h expected 00", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] addrs [6];
    logic [7:0] rd, d;
    int lat, prev_cyc;
    bit oc, to;
    for (int i = 0; i < 6; i++) begin
      addrs[i] = 8'(i * 37 + 5);
      d = 8'($urandom);
      txn(1, 1'b1, addrs[i], d, 1'b0, rd, lat, oc, to);
      m1[addrs[i]] = d;
      n_cmp++;
      if (to || lat !== 1 || !oc) begin
        n_fail++;
        $display("FAIL b2b_write%0d: lat %0d one_cycle %b timeout %b expected 1 1 0", i, lat, oc, to);
      end
    end
    prev_cyc = 0;
    for (int i = 0; i < 6; i++) begin
      txn(1, 1'b0, addrs[i], 8'h00, (i != 5), rd, lat, oc, to);
      exp_rd1 = m1[addrs[i]];
      n_cmp++;
      if (to || rd !== exp_rd1 || lat !== 1 || (i > 0 && cyc - prev_cyc !== 3)) begin
        n_fail++;
        $display("FAIL b2b_read%0d: rdata %h lat %0d period %0d expected %h 1 3",
                 i, rd, lat, cyc - prev_cyc, exp_rd1);
      end
      prev_cyc = cyc;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_random();
    test_req_during_clear();
    test_wait_change();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
